tx_pattern_gen: RTL and testbench

TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

---
 rtl/tx_pattern_gen.sv | 175 +++++++++++++++++
 tb/tb_tx_pattern_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_gen.sv
// Serial test-pattern transmitter: toggle, fixed word, PRBS7 or constant zero,
// with an optional bit budget and a per-word strobe. All outputs are registered.
module tx_pattern_gen #(
    parameter int               DATA_W  = 8,
    parameter int               CNT_W   = 32,
    parameter logic [DATA_W-1:0] PATTERN = 8'h9A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] max_tx_count,
    output logic             tx_bit_data,
    output logic             tx_valid,
    output logic             byte_strobe,
    output logic [CNT_W-1:0] bit_count,
    output logic             max_tx_flag
);

    localparam int                IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [6:0]        LFSR_SEED = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       mode_r, mode_s;
    logic [IDX_W-1:0] index_r, index_s;
    logic [IDX_W-1:0] word_r, word_s;
    logic [6:0]       lfsr_r, lfsr_s;
    logic             toggle_r, toggle_s;
    logic             data_r, data_s;
    logic             valid_r, valid_s;
    logic             strobe_r, strobe_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             flag_r, flag_s;
    logic             bit_s;
    logic             budget_on_s, last_s, over_s;

    assign budget_on_s = (max_tx_count != {CNT_W{1'b0}});
    assign last_s      = budget_on_s && ((count_r + CNT_W'(1)) == max_tx_count);
    // A budget lowered to or below the running count ends the run without another bit.
    assign over_s      = budget_on_s && (count_r >= max_tx_count);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, generator and output computation; start overrides everything.
    always_comb begin
        state_s  = state_r;
        mode_s   = mode_r;
        index_s  = index_r;
        word_s   = word_r;
        lfsr_s   = lfsr_r;
        toggle_s = toggle_r;
        data_s   = 1'b0;
        valid_s  = 1'b0;
        strobe_s = 1'b0;
        count_s  = count_r;
        flag_s   = 1'b0;
        bit_s    = 1'b0;
        if (start) begin
            state_s = ST_IDLE;
            count_s = {CNT_W{1'b0}};
            index_s = IDX_LAST;
            lfsr_s  = LFSR_SEED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_s = {CNT_W{1'b0}};
                    if (en) begin
                        state_s  = ST_RUN;
                        mode_s   = mode;
                        index_s  = IDX_LAST;
                        lfsr_s   = LFSR_SEED;
                        toggle_s = 1'b0;
                        word_s   = {IDX_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_s = ST_IDLE;
                        count_s = {CNT_W{1'b0}};
                    end else if (over_s) begin
                        state_s = ST_DONE;
                        flag_s  = 1'b1;
                    end else begin
                        case (mode_r)
                            2'b00: begin
                                bit_s    = ~toggle_r;
                                toggle_s = ~toggle_r;
                            end
                            2'b01: begin
                                bit_s   = PATTERN[index_r];
                                index_s = (index_r == {IDX_W{1'b0}}) ? IDX_LAST : (index_r - IDX_W'(1));
                            end
                            2'b10: begin
                                bit_s  = lfsr_r[6];
                                lfsr_s = {lfsr_r[5:0], lfsr_r[6] ^ lfsr_r[5]};
                            end
                            default: begin
                                bit_s = 1'b0;
                            end
                        endcase
                        data_s   = bit_s;
                        valid_s  = 1'b1;
                        strobe_s = (word_r == IDX_LAST);
                        word_s   = (word_r == IDX_LAST) ? {IDX_W{1'b0}} : (word_r + IDX_W'(1));
                        count_s  = count_r + CNT_W'(1);
                        if (last_s) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                    flag_s  = 1'b1;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= 2'b00;
            index_r  <= IDX_LAST;
            word_r   <= {IDX_W{1'b0}};
            lfsr_r   <= LFSR_SEED;
            toggle_r <= 1'b0;
            data_r   <= 1'b0;
            valid_r  <= 1'b0;
            strobe_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            flag_r   <= 1'b0;
        end else begin
            mode_r   <= mode_s;
            index_r  <= index_s;
            word_r   <= word_s;
            lfsr_r   <= lfsr_s;
            toggle_r <= toggle_s;
            data_r   <= data_s;
            valid_r  <= valid_s;
            strobe_r <= strobe_s;
            count_r  <= count_s;
            flag_r   <= flag_s;
        end
    end

    assign tx_bit_data = data_r;
    assign tx_valid    = valid_r;
    assign byte_strobe = strobe_r;
    assign bit_count   = count_r;
    assign max_tx_flag = flag_r;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Directed, table-driven bench for tx_pattern_gen with a few hand-written
// multi-cycle sequences (PRBS period, async reset, restart latency).
module tb_tx_pattern_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] max_tx_count;
    logic        tx_bit_data;
    logic        tx_valid;
    logic        byte_strobe;
    logic [31:0] bit_count;
    logic        max_tx_flag;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic        en;
        logic        start;
        logic [1:0]  mode;
        logic [31:0] max;
        logic        exp_data;
        logic        exp_valid;
        logic        exp_strobe;
        logic [31:0] exp_count;
        logic        exp_flag;
    } vec_t;

    vec_t vecs[$];

    tx_pattern_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .mode         (mode),
        .max_tx_count (max_tx_count),
        .tx_bit_data  (tx_bit_data),
        .tx_valid     (tx_valid),
        .byte_strobe  (byte_strobe),
        .bit_count    (bit_count),
        .max_tx_flag  (max_tx_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic d, input logic v, input logic s,
                                 input logic [31:0] c, input logic f);
        check({tag, ".data"},   {31'd0, tx_bit_data}, {31'd0, d});
        check({tag, ".valid"},  {31'd0, tx_valid},    {31'd0, v});
        check({tag, ".strobe"}, {31'd0, byte_strobe}, {31'd0, s});
        check({tag, ".count"},  bit_count,            c);
        check({tag, ".flag"},   {31'd0, max_tx_flag}, {31'd0, f});
    endtask

    task automatic add(input logic e, input logic st, input logic [1:0] m, input logic [31:0] mx,
                       input logic d, input logic v, input logic s, input logic [31:0] c, input logic f);
        vec_t t;
        t.en = e; t.start = st; t.mode = m; t.max = mx;
        t.exp_data = d; t.exp_valid = v; t.exp_strobe = s; t.exp_count = c; t.exp_flag = f;
        vecs.push_back(t);
    endtask

    task automatic step(input logic e, input logic st, input logic [1:0] m, input logic [31:0] mx);
        en = e; start = st; mode = m; max_tx_count = mx;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] pat;
    logic       prbs[254];
    int         ones;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        pat = 8'h9A;
        rst = 1'b1; en = 1'b0; start = 1'b0; mode = 2'b00; max_tx_count = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;

        // Fixed word, budget 16: two words, strobes on bits 8 and 16, then DONE.
        add(1'b1, 1'b0, 2'b01, 32'd16, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            add(1'b1, 1'b0, 2'b01, 32'd16, pat[7 - (i % 8)], 1'b1, (i % 8) == 7, 32'(i + 1), 1'b0);
        add(1'b1, 1'b0, 2'b01, 32'd16, 1'b0, 1'b0, 1'b0, 32'd16, 1'b1);
        add(1'b1, 1'b0, 2'b01, 32'd16, 1'b0, 1'b0, 1'b0, 32'd16, 1'b1);
        add(1'b1, 1'b1, 2'b01, 32'd16, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0);
        add(1'b0, 1'b0, 2'b01, 32'd16, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0);
        // Toggle, budget 5, then start restarts while en stays high.
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b0, 1'b1, 1'b0, 32'd4, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b1, 1'b1, 1'b0, 32'd5, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 32'd5, 1'b1);
        add(1'b1, 1'b1, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd5, 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        // Fixed word, en dropped after 3 bits, restart at MSB; mode input change ignored.
        add(1'b1, 1'b0, 2'b01, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b01, 32'd0, 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b01, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b1, 1'b0, 2'b01, 32'd0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
        add(1'b0, 1'b0, 2'b01, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b01, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd0, 1'b1, 1'b1, 1'b0, 32'd4, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        // Constant zero still counts with tx_valid high.
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b0, 1'b0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        // Start coincides with the last bit: IDLE, never DONE.
        add(1'b1, 1'b0, 2'b00, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd3, 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b00, 32'd3, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b1, 1'b1, 2'b00, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b0, 1'b0, 2'b00, 32'd3, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        // Budget lowered below the running count: DONE with count frozen.
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
        add(1'b1, 1'b0, 2'b11, 32'd1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1);
        add(1'b0, 1'b0, 2'b11, 32'd1, 1'b0, 1'b0, 1'b0, 32'd2, 1'b1);
        add(1'b0, 1'b1, 2'b11, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].start, vecs[i].mode, vecs[i].max);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                          vecs[i].exp_strobe, vecs[i].exp_count, vecs[i].exp_flag);
        end

        // PRBS7, unlimited: 254 bits, period 127, seven leading ones, 64 ones per period.
        step(1'b1, 1'b0, 2'b10, 32'd0);
        check_outputs("prbs_entry", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 254; i++) begin
            step(1'b1, 1'b0, 2'b10, 32'd0);
            prbs[i] = tx_bit_data;
            check("prbs.valid",  {31'd0, tx_valid},    32'd1);
            check("prbs.strobe", {31'd0, byte_strobe}, {31'd0, ((i % 8) == 7)});
            check("prbs.flag",   {31'd0, max_tx_flag}, 32'd0);
        end
        check("prbs.count", bit_count, 32'd254);
        for (int i = 0; i < 7; i++)
            check("prbs.seed_ones", {31'd0, prbs[i]}, 32'd1);
        ones = 0;
        for (int i = 0; i < 127; i++) begin
            check("prbs.period", {31'd0, prbs[i + 127]}, {31'd0, prbs[i]});
            ones = ones + int'(prbs[i]);
        end
        check("prbs.ones", 32'(ones), 32'd64);
        step(1'b0, 1'b0, 2'b10, 32'd0);
        check_outputs("prbs_stop", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Async reset mid-run at count 10, then two-edge restart latency.
        step(1'b1, 1'b0, 2'b01, 32'd0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 2'b01, 32'd0);
        check_outputs("pre_rst", pat[6], 1'b1, 1'b0, 32'd10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 2'b01, 32'd12);
        check_outputs("rst_edge1", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 2'b01, 32'd12);
        check_outputs("rst_edge2", 1'b1, 1'b1, 1'b0, 32'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
